// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the fetch, data and loader requesters, the arbiter,
// and the single-port SRAM macro.
interface mem_port_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic [AW-1:0] i_addr;
    logic          i_oen;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic [AW-1:0] d_addr;
    logic          d_oen;
    logic          d_wen;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ready;

    logic          m_cen;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    // Arbiter side: takes requests and memory read data, drives responses and the macro.
    modport slave (
        input  i_addr, i_oen, d_addr, d_oen, d_wen, d_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, m_rdata,
        output i_rdata, i_ready, d_rdata, d_ready, ld_rdata, ld_ready,
        output m_cen, m_wen, m_addr, m_wdata
    );

    // Requester/memory side: the mirror image of the arbiter view.
    modport master (
        output i_addr, i_oen, d_addr, d_oen, d_wen, d_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata, m_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready, ld_rdata, ld_ready,
        input  m_cen, m_wen, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one single-port SRAM between fetch, data and a boot loader,
// with a boot/run FSM, fetch-starvation guard and saturating conflict counter.
module mem_port_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_port_arbiter_if.slave bus,
    input  logic        boot_done,
    output logic        stall,
    output logic [15:0] conflict_cnt
);
    typedef enum logic [0:0] {ST_BOOT, ST_RUN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_I, TAG_D, TAG_LD} tag_t;

    localparam logic [3:0] L_MAX = 4'(MAX_STREAK);

    state_t        r_state, w_state_next;
    tag_t          r_tag, w_grant;
    logic [3:0]    r_streak, w_streak_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [15:0]   r_conflict;

    logic          w_i_req, w_d_req, w_d_wr;
    logic          w_m_cen, w_m_wen;
    logic [AW-1:0] w_m_addr;
    logic [DW-1:0] w_m_wdata;

    assign w_i_req = ~bus.i_oen;
    assign w_d_req = ~bus.d_oen | ~bus.d_wen;
    assign w_d_wr  = ~bus.d_wen;

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_BOOT && boot_done)
            w_state_next = ST_RUN;
    end

    // Loader always wins; fetch overrides data only once data has won MAX_STREAK times in a row.
    always_comb begin
        w_grant = TAG_NONE;
        if (bus.ld_req)
            w_grant = TAG_LD;
        else if (r_state == ST_RUN) begin
            if (w_i_req && w_d_req && r_streak == L_MAX)
                w_grant = TAG_I;
            else if (w_d_req)
                w_grant = TAG_D;
            else if (w_i_req)
                w_grant = TAG_I;
        end
    end

    // Address and write data hold their last driven values while the macro is idle.
    always_comb begin
        w_m_cen   = 1'b1;
        w_m_wen   = 1'b1;
        w_m_addr  = r_addr;
        w_m_wdata = r_wdata;
        case (w_grant)
            TAG_LD: begin
                w_m_cen  = 1'b0;
                w_m_wen  = ~bus.ld_we;
                w_m_addr = bus.ld_addr;
                if (bus.ld_we)
                    w_m_wdata = bus.ld_wdata;
            end
            TAG_D: begin
                w_m_cen  = 1'b0;
                w_m_wen  = ~w_d_wr;
                w_m_addr = bus.d_addr;
                if (w_d_wr)
                    w_m_wdata = bus.d_wdata;
            end
            TAG_I: begin
                w_m_cen  = 1'b0;
                w_m_addr = bus.i_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_streak_next = r_streak;
        if (w_grant == TAG_I || !w_i_req)
            w_streak_next = 4'd0;
        else if (w_grant == TAG_D && r_streak < L_MAX)
            w_streak_next = r_streak + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_tag      <= TAG_NONE;
            r_streak   <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_conflict <= 16'd0;
        end else begin
            r_state  <= w_state_next;
            r_tag    <= w_grant;
            r_streak <= w_streak_next;
            r_addr   <= w_m_addr;
            r_wdata  <= w_m_wdata;
            if (r_state == ST_RUN && w_i_req && w_d_req && r_conflict != 16'hFFFF)
                r_conflict <= r_conflict + 16'd1;
        end
    end

    assign bus.m_cen   = w_m_cen;
    assign bus.m_wen   = w_m_wen;
    assign bus.m_addr  = w_m_addr;
    assign bus.m_wdata = w_m_wdata;

    // Read data is steered to whichever port owned the macro on the previous cycle.
    assign bus.i_ready  = (r_tag == TAG_I);
    assign bus.d_ready  = (r_tag == TAG_D);
    assign bus.ld_ready = (r_tag == TAG_LD);
    assign bus.i_rdata  = bus.i_ready  ? bus.m_rdata : '0;
    assign bus.d_rdata  = bus.d_ready  ? bus.m_rdata : '0;
    assign bus.ld_rdata = bus.ld_ready ? bus.m_rdata : '0;

    assign stall        = (w_i_req && w_grant != TAG_I) || (w_d_req && w_grant != TAG_D);
    assign conflict_cnt = r_conflict;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port SRAM attached.
module tb_mem_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;

    logic        clk;
    logic        rst_n;
    logic        boot_done;
    logic        stall;
    logic [15:0] conflict_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_conflict = 0;

    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] mem_rdata = '0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .boot_done    (boot_done),
        .stall        (stall),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous SRAM model: read data appears the cycle after the address edge.
    always @(posedge clk) begin
        if (!bus.m_cen) begin
            if (!bus.m_wen)
                mem[bus.m_addr] = bus.m_wdata;
            else
                mem_rdata <= mem[bus.m_addr];
        end
    end
    assign bus.m_rdata = mem_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_reqs();
        bus.i_oen  = 1'b1;
        bus.d_oen  = 1'b1;
        bus.d_wen  = 1'b1;
        bus.ld_req = 1'b0;
        boot_done  = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_i_ready"},  32'(bus.i_ready),  32'd0);
        check({pfx, "_d_ready"},  32'(bus.d_ready),  32'd0);
        check({pfx, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
        check({pfx, "_m_cen"},    32'(bus.m_cen),    32'd1);
        check({pfx, "_m_wen"},    32'(bus.m_wen),    32'd1);
        check({pfx, "_m_addr"},   32'(bus.m_addr),   32'd0);
        check({pfx, "_m_wdata"},  bus.m_wdata,       32'd0);
        check({pfx, "_i_rdata"},  bus.i_rdata,       32'd0);
        check({pfx, "_d_rdata"},  bus.d_rdata,       32'd0);
        check({pfx, "_ld_rdata"}, bus.ld_rdata,      32'd0);
        check({pfx, "_conflict"}, 32'(conflict_cnt), 32'd0);
        check({pfx, "_stall"},    32'(stall),        32'd0);
    endtask

    logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = 32'h1000_0000 + 32'(i);

        rst_n = 1'b0;
        idle_reqs();
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
        step();
        step();
        check_reset_state("rst");

        // BOOT: fetch request is refused
        rst_n = 1'b1;
        step();
        bus.i_oen = 1'b0; bus.i_addr = 11'd5;
        #1;
        check("boot_stall", 32'(stall), 32'd1);
        check("boot_m_cen", 32'(bus.m_cen), 32'd1);
        $display("txn boot fetch refused: stall=%0d m_cen=%0d", stall, bus.m_cen);

        // BOOT: loader write
        step();
        bus.i_oen = 1'b1;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 11'd5; bus.ld_wdata = 32'hDEAD_BEEF;
        #1;
        check("ldw_m_cen",   32'(bus.m_cen),  32'd0);
        check("ldw_m_wen",   32'(bus.m_wen),  32'd0);
        check("ldw_m_addr",  32'(bus.m_addr), 32'd5);
        check("ldw_m_wdata", bus.m_wdata,     32'hDEAD_BEEF);
        step();
        bus.ld_req = 1'b0;
        #1;
        check("ldw_ready",     32'(bus.ld_ready), 32'd1);
        check("ldw_idle_cen",  32'(bus.m_cen),    32'd1);
        check("ldw_hold_addr", 32'(bus.m_addr),   32'd5);
        $display("txn loader write addr=5 data=deadbeef ld_ready=%0d", bus.ld_ready);

        // Enter RUN and fetch address 5
        step();
        boot_done = 1'b1;
        step();
        boot_done = 1'b0;
        bus.i_oen = 1'b0; bus.i_addr = 11'd5;
        #1;
        check("f5_m_cen",  32'(bus.m_cen),  32'd0);
        check("f5_m_addr", 32'(bus.m_addr), 32'd5);
        check("f5_m_wen",  32'(bus.m_wen),  32'd1);
        check("f5_stall",  32'(stall),      32'd0);
        step();
        bus.i_oen = 1'b1;
        #1;
        check("f5_i_ready", 32'(bus.i_ready), 32'd1);
        check("f5_i_rdata", bus.i_rdata,      32'hDEAD_BEEF);
        $display("txn fetch addr=5 rdata=%h", bus.i_rdata);

        // Fetch and data read contend every cycle: D,D,D,D,I repeating
        step();
        bus.i_oen = 1'b0; bus.i_addr = 11'd10;
        bus.d_oen = 1'b0; bus.d_addr = 11'd20;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("fair%0d_m_addr", k), 32'(bus.m_addr), exp_d[k] ? 32'd20 : 32'd10);
            check($sformatf("fair%0d_stall", k), 32'(stall), 32'd1);
            check($sformatf("fair%0d_conflict", k), 32'(conflict_cnt), 32'(exp_conflict));
            if (k > 0) begin
                check($sformatf("fair%0d_d_ready", k), 32'(bus.d_ready), exp_d[k-1] ? 32'd1 : 32'd0);
                check($sformatf("fair%0d_i_ready", k), 32'(bus.i_ready), exp_d[k-1] ? 32'd0 : 32'd1);
                if (exp_d[k-1])
                    check($sformatf("fair%0d_d_rdata", k), bus.d_rdata, 32'h1000_0014);
                else
                    check($sformatf("fair%0d_i_rdata", k), bus.i_rdata, 32'h1000_000A);
            end
            $display("txn contend cycle %0d grant=%s m_addr=%0d", k, exp_d[k] ? "D" : "I", bus.m_addr);
            step();
            exp_conflict++;
        end
        bus.i_oen = 1'b1; bus.d_oen = 1'b1;
        #1;
        check("fair_last_i_ready", 32'(bus.i_ready), 32'd1);
        check("fair_last_i_rdata", bus.i_rdata,      32'h1000_000A);
        check("fair_conflict",     32'(conflict_cnt), 32'(exp_conflict));

        // Write with both data strobes low, then read it back
        step();
        bus.d_wen = 1'b0; bus.d_oen = 1'b0; bus.d_addr = 11'd7; bus.d_wdata = 32'd3;
        #1;
        check("dw_m_wen",   32'(bus.m_wen),  32'd0);
        check("dw_m_addr",  32'(bus.m_addr), 32'd7);
        check("dw_m_wdata", bus.m_wdata,     32'd3);
        step();
        bus.d_wen = 1'b1;
        #1;
        check("dw_d_ready", 32'(bus.d_ready), 32'd1);
        check("dr_m_wen",   32'(bus.m_wen),   32'd1);
        check("dr_m_cen",   32'(bus.m_cen),   32'd0);
        step();
        bus.d_oen = 1'b1;
        #1;
        check("dr_d_ready", 32'(bus.d_ready), 32'd1);
        check("dr_d_rdata", bus.d_rdata,      32'd3);
        $display("txn data write/read addr=7 rdata=%0d", bus.d_rdata);

        // Loader cuts into a RUN fetch stream
        step();
        bus.i_oen = 1'b0; bus.i_addr = 11'd30;
        #1;
        check("ls_f30_addr", 32'(bus.m_addr), 32'd30);
        step();
        bus.i_addr = 11'd31;
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 11'd40;
        #1;
        check("ls_ld_addr",  32'(bus.m_addr),  32'd40);
        check("ls_ld_wen",   32'(bus.m_wen),   32'd1);
        check("ls_stall",    32'(stall),       32'd1);
        check("ls_i_ready",  32'(bus.i_ready), 32'd1);
        check("ls_i_rdata",  bus.i_rdata,      32'h1000_001E);
        step();
        bus.ld_req = 1'b0;
        #1;
        check("ls_f31_addr",  32'(bus.m_addr),   32'd31);
        check("ls_f31_stall", 32'(stall),        32'd0);
        check("ls_ld_ready",  32'(bus.ld_ready), 32'd1);
        check("ls_ld_rdata",  bus.ld_rdata,      32'h1000_0028);
        step();
        bus.i_oen = 1'b1;
        #1;
        check("ls_f31_ready", 32'(bus.i_ready), 32'd1);
        check("ls_f31_rdata", bus.i_rdata,      32'h1000_001F);
        $display("txn loader read addr=40 during fetch stream rdata=%h", bus.ld_rdata);

        // Drive the conflict counter to saturation
        step();
        bus.i_oen = 1'b0; bus.d_oen = 1'b0;
        repeat (16'hFFFE - exp_conflict) step();
        check("sat_fffe", 32'(conflict_cnt), 32'h0000_FFFE);
        repeat (3) step();
        check("sat_ffff", 32'(conflict_cnt), 32'h0000_FFFF);
        $display("txn conflict saturation conflict_cnt=%h", conflict_cnt);

        // Reset while a grant is being issued
        check("rst_grant_live", 32'(bus.m_cen), 32'd0);
        rst_n = 1'b0;
        step();
        idle_reqs();
        #1;
        check_reset_state("midrst");
        $display("txn reset mid-transaction i_ready=%0d d_ready=%0d", bus.i_ready, bus.d_ready);

        rst_n = 1'b1;
        step();
        bus.i_oen = 1'b0; bus.i_addr = 11'd5;
        #1;
        check("reboot_stall", 32'(stall),     32'd1);
        check("reboot_m_cen", 32'(bus.m_cen), 32'd1);
        $display("txn post-reset fetch refused in boot stall=%0d", stall);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
